// File: rtl/CLA_16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second-level group carry network.
module CLA_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_group
            assign gg[gi] = g[4*gi+3]
                          | (p[4*gi+3] & g[4*gi+2])
                          | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                          | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
            assign gp[gi] = &p[4*gi +: 4];

            // In-group carries look ahead from the group's carry-in
            assign c[4*gi]   = gc[gi];
            assign c[4*gi+1] = g[4*gi] | (p[4*gi] & gc[gi]);
            assign c[4*gi+2] = g[4*gi+1]
                             | (p[4*gi+1] & g[4*gi])
                             | (p[4*gi+1] & p[4*gi] & gc[gi]);
            assign c[4*gi+3] = g[4*gi+2]
                             | (p[4*gi+2] & g[4*gi+1])
                             | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                             | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & gc[gi]);
        end
    endgenerate

    assign gc[0] = ci;
    assign gc[1] = gg[0] | (gp[0] & ci);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & ci);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

    assign s  = p ^ c;
    assign co = gc[4];

endmodule

// File: rtl/add_seq_16.sv
// Wide add/subtract sequencer: one shared CLA_16 processes WIDTH/16 slices,
// LSB first, with the carry held in a register between slices.
module add_seq_16 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / 16;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 16) || ((WIDTH % 16) != 0)) begin : g_bad_width
            $error("add_seq_16: WIDTH must be a positive multiple of 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [KW-1:0]   k_reg;
    logic            carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic            co_reg;
    logic            ovf_reg;
    logic            out_valid_reg;

    logic [15:0]     a_slice;
    logic [15:0]     b_slice;
    logic [15:0]     s_slice;
    logic            co_slice;
    logic            last_slice;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < N; i++) begin
            if (k_reg == KW'(i)) begin
                a_slice = a_reg[16*i +: 16];
                b_slice = b_reg[16*i +: 16];
            end
        end
    end

    assign last_slice = (k_reg == KW'(N - 1));

    CLA_16 u_cla (
        .a  (a_slice),
        .b  (b_slice),
        .ci (carry_reg),
        .s  (s_slice),
        .co (co_slice)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            co_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B, seed the carry
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        k_reg     <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (k_reg == KW'(i)) sum_reg[16*i +: 16] <= s_slice;
                    end
                    carry_reg <= co_slice;
                    k_reg     <= k_reg + KW'(1);
                    if (last_slice) begin
                        co_reg        <= co_slice;
                        ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                         (s_slice[15] != a_reg[WIDTH-1]);
                        out_valid_reg <= 1'b1;
                        k_reg         <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign co        = co_reg;
    assign ovf       = ovf_reg;

endmodule
